// File: rtl/seq_alu_pkg.sv
// Shared definitions for seq_alu: opcodes, FSM states and divider special-case results.
// Result-constant helpers cover operand widths up to MAX_W bits.
package seq_alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_XOR = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0111;
  localparam logic [3:0] OP_DIV = 4'b1000;
  localparam logic [3:0] OP_REM = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MAX_W = 256;

  // Quotient for divide-by-zero: all ones in the low w bits.
  function automatic logic [MAX_W-1:0] all_ones_w(input int w);
    return {MAX_W{1'b1}} >> (MAX_W - w);
  endfunction

  // Most-negative w-bit value; also the quotient of the min/-1 overflow case.
  function automatic logic [MAX_W-1:0] min_neg_w(input int w);
    logic [MAX_W-1:0] one;
    one    = '0;
    one[0] = 1'b1;
    return one << (w - 1);
  endfunction

endpackage

// File: rtl/seq_alu_div.sv
// Iterative signed restoring divider: one quotient bit per cycle on magnitudes, sign fix-up
// applied combinationally to the final step so the result is ready as done_o is high.
module seq_alu_div
  import seq_alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o
);

  localparam logic [WIDTH-1:0] ALL_ONES = WIDTH'(all_ones_w(WIDTH));
  localparam logic [WIDTH-1:0] MIN_NEG  = WIDTH'(min_neg_w(WIDTH));

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvsr_q, dvnd_q;
  logic             qneg_q, rneg_q, dz_q, ovf_q;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] rem_n, quo_n;

  assign done_o = busy_q && (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr_q};
    if (trial[WIDTH]) begin
      rem_n = shifted[WIDTH-1:0];
      quo_n = {quo_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_n = trial[WIDTH-1:0];
      quo_n = {quo_q[WIDTH-2:0], 1'b1};
    end
    if (dz_q) begin
      quot_o = ALL_ONES;
      rem_o  = dvnd_q;
    end else if (ovf_q) begin
      quot_o = MIN_NEG;
      rem_o  = '0;
    end else begin
      quot_o = qneg_q ? -quo_n : quo_n;
      rem_o  = rneg_q ? -rem_n : rem_n;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
      dvnd_q <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= mag(a_i);
      dvsr_q <= mag(b_i);
      dvnd_q <= a_i;
      qneg_q <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
      rneg_q <= a_i[WIDTH-1];
      dz_q   <= (b_i == '0);
      ovf_q  <= (a_i == MIN_NEG) && (b_i == ALL_ONES);
    end else if (busy_q) begin
      rem_q  <= rem_n;
      quo_q  <= quo_n;
      cnt_q  <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshakes; MUL is iterative shift-add over WIDTH cycles.
// Define SEQ_ALU_DIV_EN to build in the iterative signed divider (DIV/REM opcodes).
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             Zero_o
);

  function automatic logic signed [WIDTH-1:0] simple_op(input logic [3:0] op,
                                                       input logic signed [WIDTH-1:0] a,
                                                       input logic signed [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] r;
    r = '0;
    case (op)
      OP_AND:  r = a & b;
      OP_XOR:  r = a ^ b;
      OP_ADD:  r = a + b;
      OP_OR:   r = a | b;
      OP_SRA:  r = a >>> b[SHW-1:0];
      OP_SUB:  r = a - b;
      OP_SLL:  r = a << b[SHW-1:0];
      default: r = '0;
    endcase
    return r;
  endfunction

  state_e                  state_q, state_d;
  logic [3:0]              op_q;
  logic signed [WIDTH-1:0] a_q, b_q, acc_q, res_q;
  logic signed [WIDTH-1:0] acc_next, long_res;
  logic [SHW-1:0]          cnt_q;
  logic                    accept, div_op, long_op, last_step, div_done;

  assign accept   = valid_i && (state_q == IDLE);
  assign acc_next = b_q[0] ? acc_q + a_q : acc_q;

`ifdef SEQ_ALU_DIV_EN
  logic             div_start;
  logic [WIDTH-1:0] div_quot, div_rem;

  assign div_op    = (ALUCtrl_i == OP_DIV) || (ALUCtrl_i == OP_REM);
  assign div_start = accept && div_op;

  seq_alu_div #(.WIDTH(WIDTH)) u_div (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (div_start),
    .a_i     (data1_i),
    .b_i     (data2_i),
    .done_o  (div_done),
    .quot_o  (div_quot),
    .rem_o   (div_rem)
  );

  always_comb begin
    long_res = acc_next;
    if (op_q == OP_DIV)      long_res = $signed(div_quot);
    else if (op_q == OP_REM) long_res = $signed(div_rem);
  end
`else
  assign div_op   = 1'b0;
  assign div_done = 1'b0;
  assign long_res = acc_next;
`endif

  assign long_op   = (ALUCtrl_i == OP_MUL) || div_op;
  // MUL finishes on its own step count; DIV/REM follow the divider's done strobe.
  assign last_step = (op_q == OP_MUL) ? (cnt_q == SHW'(WIDTH - 1)) : div_done;

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign data_o  = res_q;
  assign Zero_o  = (res_q == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_i) state_d = long_op ? BUSY : DONE;
      BUSY:    if (last_step) state_d = DONE;
      DONE:    if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      res_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (valid_i) begin
          op_q  <= ALUCtrl_i;
          a_q   <= data1_i;
          b_q   <= data2_i;
          acc_q <= '0;
          cnt_q <= '0;
          if (!long_op) res_q <= simple_op(ALUCtrl_i, data1_i, data2_i);
        end
        BUSY: begin
          // Multiplicand walks left, multiplier walks right one bit per step.
          acc_q <= acc_next;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + 1'b1;
          if (last_step) res_q <= long_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed corner cases plus random ops against an
// arithmetic reference model (divider expectations follow SEQ_ALU_DIV_EN).
module tb_seq_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         valid_i, ready_o, valid_o, ready_i, Zero_o;
  logic [3:0]   ALUCtrl_i;
  logic [W-1:0] data1_i, data2_i, data_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .ALUCtrl_i (ALUCtrl_i),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .data_o    (data_o),
    .Zero_o    (Zero_o)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit div_built();
`ifdef SEQ_ALU_DIV_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [W-1:0] ref_result(input logic [3:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    logic signed [W-1:0] sa, sb;
    longint prod;
    logic [63:0] p;
    sa = a;
    sb = b;
    case (op)
      4'd0: return a & b;
      4'd1: return a ^ b;
      4'd2: return a + b;
      4'd3: begin
        prod = longint'(sa) * longint'(sb);
        p = prod;
        return p[W-1:0];
      end
      4'd4: return a | b;
      4'd5: return sa >>> b[4:0];
      4'd6: return a - b;
      4'd7: return a << b[4:0];
      4'd8, 4'd9: begin
        if (!div_built()) return '0;
        if (b == 0) return (op == 4'd8) ? 32'hFFFF_FFFF : a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return (op == 4'd8) ? a : 32'h0;
        return (op == 4'd8) ? W'(sa / sb) : W'(sa % sb);
      end
      default: return '0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] op);
    if (op == 4'd3) return W + 1;
    if (div_built() && (op == 4'd8 || op == 4'd9)) return W + 1;
    return 1;
  endfunction

  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int hold);
    logic [W-1:0] exp;
    int lat, bad_busy, exp_lat;
    exp     = ref_result(op, a, b);
    exp_lat = ref_latency(op);
    @(negedge clk);
    check_val({tag, "/ready_in"}, ready_o, 1);
    valid_i = 1'b1; ALUCtrl_i = op; data1_i = a; data2_i = b;
    @(negedge clk);
    valid_i = 1'b0; ALUCtrl_i = 4'($urandom); data1_i = $urandom; data2_i = $urandom;
    lat = 1;
    bad_busy = 0;
    while (!valid_o && lat < 200) begin
      if (ready_o) bad_busy++;
      valid_i = (lat == 5);  // stray request while busy must be ignored
      @(negedge clk);
      lat++;
    end
    valid_i = 1'b0;
    check_val({tag, "/latency"}, lat, exp_lat);
    check_val({tag, "/data"}, data_o, exp);
    check_val({tag, "/zero"}, Zero_o, exp == 0);
    if (exp_lat > 1) check_val({tag, "/busy_ready"}, bad_busy, 0);
    for (int i = 0; i < hold; i++) begin
      ready_i = 1'b0;
      @(negedge clk);
      check_val({tag, "/hold_data"}, data_o, exp);
      check_val({tag, "/hold_valid"}, valid_o, 1);
      check_val({tag, "/hold_ready"}, ready_o, 0);
    end
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    check_val({tag, "/handoff_ready"}, ready_o, 1);
    check_val({tag, "/handoff_valid"}, valid_o, 0);
  endtask

  initial begin
    logic [3:0]   op;
    logic [W-1:0] a, b;
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    ALUCtrl_i = '0; data1_i = '0; data2_i = '0;
    #2 rst_i = 1'b0;
    #1;
    check_val("rst/ready", ready_o, 1);
    check_val("rst/valid", valid_o, 0);
    check_val("rst/data", data_o, 0);
    check_val("rst/zero", Zero_o, 1);
    repeat (2) @(negedge clk);
    rst_i = 1'b1;

    run_op("add", 4'd2, 32'd5, 32'd7, 0);
    run_op("sub", 4'd6, 32'd9, 32'd9, 0);
    run_op("sra", 4'd5, 32'h8000_0000, 32'h24, 1);
    run_op("sll", 4'd7, 32'd1, 32'd31, 0);
    run_op("mul", 4'd3, 32'hFFFF_FFFD, 32'd7, 0);
    run_op("div", 4'd8, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("rem", 4'd9, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("div0", 4'd8, 32'd5, 32'd0, 0);
    run_op("rem0", 4'd9, 32'd5, 32'd0, 0);
    run_op("divovf", 4'd8, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("removf", 4'd9, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("illegal", 4'hF, 32'h1234, 32'h5678, 0);
    run_op("xor_bp", 4'd1, 32'hFF, 32'h0F, 3);

    // Abort a multiply mid-flight with an asynchronous reset.
    @(negedge clk);
    valid_i = 1'b1; ALUCtrl_i = 4'd3; data1_i = 32'hFFFF_FFFD; data2_i = 32'd7;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_i = 1'b0;
    #1;
    check_val("abort/valid", valid_o, 0);
    check_val("abort/ready", ready_o, 1);
    check_val("abort/data", data_o, 0);
    check_val("abort/zero", Zero_o, 1);
    @(negedge clk);
    rst_i = 1'b1;
    run_op("and_after_rst", 4'd0, 32'hC, 32'hA, 0);

    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(0, 15));
      if (n % 3 == 0) op = 4'($urandom_range(8, 9));
      if (n % 5 == 1) op = 4'd3;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = $urandom_range(0, 40);
        4: a = 32'h8000_0000;
        default: ;
      endcase
      run_op($sformatf("rnd%0d_op%0d", n, op), op, a, b, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Multi-cycle, parametrised successor to the single-cycle datapath ALU. Supports the same eight operations plus signed divide and remainder. Multiply and divide run iteratively over WIDTH cycles instead of through a combinational multiplier, and operands/results move over valid/ready handshakes. Sits in the EX stage; the hazard unit stalls the pipeline while `ready_o` or `valid_o` says the unit is not available.

## Interface
- `WIDTH`, 32: operand/result width, ≥ 8, power of two.
- `SHW`, $clog2(WIDTH): shift-amount width (derived, not overridden).
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `valid_i` in 1: operation request.
- `ready_o` out 1: unit can accept a request (IDLE).
- `ALUCtrl_i` in 4: opcode.
- `data1_i` in WIDTH: operand A (signed).
- `data2_i` in WIDTH: operand B (signed).
- `valid_o` out 1: result available.
- `ready_i` in 1: consumer takes result.
- `data_o` out WIDTH: result.
- `Zero_o` out 1: `data_o == 0`, valid with `valid_o`.

## Operation
- Opcodes:
  - AND 0000, XOR 0001, ADD 0010, MUL 0011, OR 0100, SRA 0101, SUB 0110, SLL 0111.
  - DIV 1000, REM 1001.
  - Others are illegal: result 0, single-cycle path.
- FSM states:
  - IDLE: `ready_o`=1. On `valid_i`, latch operands and opcode. Simple ops compute into the result register and go to DONE. MUL/DIV/REM go to BUSY with step counter = 0.
  - BUSY: one iteration per cycle. After step WIDTH-1, write the result and go to DONE.
  - DONE: `valid_o`=1, `data_o`/`Zero_o` held stable. On `ready_i`, go to IDLE. No new request is accepted in DONE or BUSY.
- Arithmetic:
  - All arithmetic is two's complement, WIDTH bits, wrap-around; no carry/overflow output.
  - Shifts use `data2_i[SHW-1:0]` only. SRA is arithmetic; SLL fills with zeros.
- MUL: shift-add on latched operands; result = low WIDTH bits of the product. The low half is sign-agnostic.
- DIV/REM: restoring division on magnitudes, then sign fix-up. Quotient is truncated toward zero; the remainder takes the dividend's sign.
  - Divide by zero: DIV = all ones; REM = dividend.
  - Overflow (most-negative / -1): DIV = dividend; REM = 0.
  - Both special cases still take WIDTH+1 cycles, so latency is data-independent.
- Operand inputs are don't-care outside the accepting cycle.

## Timing
- Accept cycle = `valid_i & ready_o` at the clock edge.
- Simple ops: `valid_o` rises 1 cycle after accept.
- MUL/DIV/REM: `valid_o` rises WIDTH+1 cycles after accept.
- Result handoff = `valid_o & ready_i` edge; `ready_o` is 1 in the next cycle. Back-to-back throughput for simple ops is 1 op per 2 cycles.
- `ready_o` is combinational from state only, never from `valid_i`.
- Reset:
  - Outputs: `ready_o`=1, `valid_o`=0, `data_o`=0, `Zero_o`=1.
  - State = IDLE; counter and operand registers = 0.
  - Asserting `rst_i` low mid-BUSY or mid-DONE aborts immediately. The result is discarded; nothing is replayed.

## Configuration
- `SEQ_ALU_DIV_EN` defined: DIV/REM behave as above, and the divider sub-module is instantiated.
- `SEQ_ALU_DIV_EN` undefined: the divider is absent. 1000/1001 are illegal opcodes: result 0, `Zero_o`=1, 1-cycle latency.
- MUL and all other behaviour are identical in both builds.

## Structure
- `seq_alu_pkg` holds:
  - the opcode localparams (4-bit),
  - the FSM state enum (IDLE/BUSY/DONE),
  - the divide-by-zero and overflow result constants, as functions of WIDTH.
- Sub-module `seq_alu_div`:
  - iterative signed divider with start/done;
  - parametrised by WIDTH;
  - instantiated only under `SEQ_ALU_DIV_EN`.
- MUL iteration and the simple ops stay in the top level.

## Test plan
All scenarios use WIDTH=32 unless stated.
- ADD 5+7, `ready_i`=1 → `data_o`=12, `Zero_o`=0, `valid_o` 1 cycle after accept, `ready_o` high the following cycle.
- SUB 9-9 → 0, `Zero_o`=1. SRA 0x80000000 by 0x24 (shift 4) → 0xF8000000. SLL 1 by 31 → 0x80000000.
- MUL -3×7 → 0xFFFFFFEB exactly 33 cycles after accept; `ready_o`=0 throughout; a `valid_i` pulse during BUSY is ignored.
- Divider cases (`SEQ_ALU_DIV_EN` defined), each 33 cycles:
  - DIV -7/2 → 0xFFFFFFFD; REM -7%2 → 0xFFFFFFFF.
  - DIV 5/0 → 0xFFFFFFFF; REM 5%0 → 5.
  - DIV 0x80000000/-1 → 0x80000000.
- Backpressure: hold `ready_i`=0 for 3 cycles in DONE after XOR 0xFF^0x0F → `data_o`=0xF0 stable, `valid_o`=1, `ready_o`=0; release → IDLE next cycle.
- Reset and build option:
  - Assert `rst_i` low at cycle 10 of a MUL → `valid_o`=0, `ready_o`=1, `data_o`=0 asynchronously; next request (AND 0xC & 0xA) → 0x8.
  - Build without the macro: DIV opcode → 0 after 1 cycle.
